// File: rtl/seq_clic.sv
// rtl/seq_clic.sv - sequential nesting interrupt controller with a threshold preemption stack.
// Optional CLIC_EDGE_EN adds per-source edge/level selection (edge_cfg) and edge detect registers.
module seq_clic #(
  parameter int NrSources  = 4,
  parameter int PrioWidth  = 3,
  parameter int StackDepth = 4,
  localparam int SrcWidth  = $clog2(NrSources),
  localparam int PtrWidth  = $clog2(StackDepth + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NrSources-1:0] irq_i,
  input  logic [NrSources-1:0] e,
  input  logic [PrioWidth-1:0] prio [NrSources],
`ifdef CLIC_EDGE_EN
  input  logic [NrSources-1:0] edge_cfg,
`endif
  input  logic                 claim,
  input  logic                 complete,
  output logic                 irq_req,
  output logic [SrcWidth-1:0]  index,
  output logic [PrioWidth-1:0] irq_prio,
  output logic [PrioWidth-1:0] t,
  output logic [PtrWidth-1:0]  depth
);

  logic [NrSources-1:0] pend, pend_nxt;
  logic [PrioWidth-1:0] stack [StackDepth];
  logic [PrioWidth-1:0] stack_top;
  logic                 found;
  logic [SrcWidth-1:0]  win_idx;
  logic [PrioWidth-1:0] win_prio;
  logic                 claim_acc, pop;
  logic [PrioWidth-1:0] t_after_pop;
  logic [PtrWidth-1:0]  depth_after_pop;

  assign claim_acc       = claim & irq_req;
  assign pop             = complete & (depth != '0);
  assign t_after_pop     = pop ? stack_top : t;
  assign depth_after_pop = pop ? depth - PtrWidth'(1) : depth;

  always_comb begin
    stack_top = '0;
    for (int j = 0; j < StackDepth; j++) begin
      if (PtrWidth'(j) == depth - PtrWidth'(1)) stack_top = stack[j];
    end
  end

`ifdef CLIC_EDGE_EN
  logic [NrSources-1:0] irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= '0;
    else       irq_q <= irq_i;
  end

  // A fresh edge wins over the claim-clear of the same source.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NrSources; i++) begin
      if (edge_cfg[i])
        pend_nxt[i] = (irq_i[i] & ~irq_q[i]) |
                      (pend[i] & ~(claim_acc && (index == SrcWidth'(i))));
      else
        pend_nxt[i] = irq_i[i];
    end
  end
`else
  always_comb begin
    pend_nxt = irq_i;
  end
`endif

  // Highest priority wins; >= lets the higher index take ties.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int i = 0; i < NrSources; i++) begin
      if (pend[i] && e[i] && (prio[i] > t) && (!found || prio[i] >= win_prio)) begin
        found    = 1'b1;
        win_idx  = SrcWidth'(i);
        win_prio = prio[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      irq_req  <= 1'b0;
      index    <= '0;
      irq_prio <= '0;
    end else begin
      pend <= pend_nxt;
      // Suppress the offer right after a claim so the old winner is not re-offered
      // before the raised threshold has been applied.
      if (found && (depth != PtrWidth'(StackDepth)) && !claim_acc) begin
        irq_req  <= 1'b1;
        index    <= win_idx;
        irq_prio <= win_prio;
      end else begin
        irq_req  <= 1'b0;
      end
    end
  end

  // Complete pops first; a simultaneous claim then pushes the restored threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      t     <= '0;
      depth <= '0;
      for (int j = 0; j < StackDepth; j++) stack[j] <= '0;
    end else if (claim_acc) begin
      t     <= irq_prio;
      depth <= depth_after_pop + PtrWidth'(1);
      for (int j = 0; j < StackDepth; j++) begin
        if (PtrWidth'(j) == depth_after_pop) stack[j] <= t_after_pop;
      end
    end else begin
      t     <= t_after_pop;
      depth <= depth_after_pop;
    end
  end

endmodule

// File: tb/tb_seq_clic.sv
// tb/tb_seq_clic.sv - directed self-checking bench for seq_clic (StackDepth=2).
// Edge-source scenarios are built only when CLIC_EDGE_EN is defined.
module tb_seq_clic;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_i;
  logic [3:0] e;
  logic [2:0] prio [4];
  logic [3:0] edge_cfg;
  logic       claim;
  logic       complete;
  logic       irq_req;
  logic [1:0] index;
  logic [2:0] irq_prio;
  logic [2:0] t;
  logic [1:0] depth;
  logic [10:0] obs;
  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {irq_req, index, irq_prio, t, depth};

  always #5 clk = ~clk;

  seq_clic #(.NrSources(4), .PrioWidth(3), .StackDepth(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_i    (irq_i),
    .e        (e),
    .prio     (prio),
`ifdef CLIC_EDGE_EN
    .edge_cfg (edge_cfg),
`endif
    .claim    (claim),
    .complete (complete),
    .irq_req  (irq_req),
    .index    (index),
    .irq_prio (irq_prio),
    .t        (t),
    .depth    (depth)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; claim = 1'b0; complete = 1'b0; irq_i = 4'b0000;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; claim = 1'b0; complete = 1'b0; edge_cfg = 4'b0000;
    irq_i = 4'b1111; e = 4'b1111;
    for (int i = 0; i < 4; i++) prio[i] = 3'd1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (obs !== 11'd0) begin
        $display("FAIL reset_during[%0d]: got %h expected %h", c, obs, 11'd0); n_fail++;
      end
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (obs !== 11'd0) begin
      $display("FAIL reset_after_release: got %h expected %h", obs, 11'd0); n_fail++;
    end
  endtask

  task automatic test_ties_threshold();
    tick();
    n_checks++;
    if (obs !== {1'b1, 2'd3, 3'd1, 3'd0, 2'd0}) begin
      $display("FAIL tie_highest_index: got %h expected %h", obs, {1'b1, 2'd3, 3'd1, 3'd0, 2'd0}); n_fail++;
    end
    for (int i = 0; i < 4; i++) prio[i] = 3'd0;
    tick();
    n_checks++;
    if (obs !== {1'b0, 2'd3, 3'd1, 3'd0, 2'd0}) begin
      $display("FAIL prio0_no_req_hold: got %h expected %h", obs, {1'b0, 2'd3, 3'd1, 3'd0, 2'd0}); n_fail++;
    end
  endtask

  task automatic test_nesting_stack_full();
    do_reset();
    prio[0] = 3'd2; prio[1] = 3'd3; prio[2] = 3'd5; prio[3] = 3'd1;
    e = 4'b1111; irq_i = 4'b0001;
    tick();
    n_checks++;
    if (irq_req !== 1'b0) begin
      $display("FAIL latency_pend_edge: got %b expected %b", irq_req, 1'b0); n_fail++;
    end
    tick();
    n_checks++;
    if (obs !== {1'b1, 2'd0, 3'd2, 3'd0, 2'd0}) begin
      $display("FAIL nest_offer0: got %h expected %h", obs, {1'b1, 2'd0, 3'd2, 3'd0, 2'd0}); n_fail++;
    end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 2'd0, 3'd2, 3'd2, 2'd1}) begin
      $display("FAIL nest_claim0: got %h expected %h", obs, {1'b0, 2'd0, 3'd2, 3'd2, 2'd1}); n_fail++;
    end
    tick();
    n_checks++;
    if (irq_req !== 1'b0) begin
      $display("FAIL no_reoffer_at_t: got %b expected %b", irq_req, 1'b0); n_fail++;
    end
    irq_i = 4'b0101;
    tick(); tick();
    n_checks++;
    if (obs !== {1'b1, 2'd2, 3'd5, 3'd2, 2'd1}) begin
      $display("FAIL nest_offer2: got %h expected %h", obs, {1'b1, 2'd2, 3'd5, 3'd2, 2'd1}); n_fail++;
    end
    claim = 1'b1;
    tick();
    claim = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 2'd2, 3'd5, 3'd5, 2'd2}) begin
      $display("FAIL nest_claim2: got %h expected %h", obs, {1'b0, 2'd2, 3'd5, 3'd5, 2'd2}); n_fail++;
    end
    prio[3] = 3'd7; irq_i = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (irq_req !== 1'b0) begin
        $display("FAIL stack_full_blocks[%0d]: got %b expected %b", c, irq_req, 1'b0); n_fail++;
      end
    end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    n_checks++;
    if (obs !== {1'b0, 2'd2, 3'd5, 3'd2, 2'd1}) begin
      $display("FAIL complete_pop1: got %h expected %h", obs, {1'b0, 2'd2, 3'd5, 3'd2, 2'd1}); n_fail++;
    end
    tick();
    n_checks++;
    if (obs !== {1'b1, 2'd3, 3'd7, 3'd2, 2'd1}) begin
      $display("FAIL offer_after_pop: got %h expected %h", obs, {1'b1, 2'd3, 3'd7, 3'd2, 2'd1}); n_fail++;
    end
    irq_i = 4'b0000; complete = 1'b1;
    tick();
    n_checks++;
    if ({t, depth} !== {3'd0, 2'd0}) begin
      $display("FAIL complete_pop0: got t=%0d depth=%0d expected t=0 depth=0", t, depth); n_fail++;
    end
    tick();
    complete = 1'b0;
    n_checks++;
    if ({t, depth} !== {3'd0, 2'd0}) begin
      $display("FAIL extra_complete: got t=%0d depth=%0d expected t=0 depth=0", t, depth); n_fail++;
    end
    claim = 1'b1;
    tick(); tick();
    claim = 1'b0;
    n_checks++;
    if ({irq_req, t, depth} !== {1'b0, 3'd0, 2'd0}) begin
      $display("FAIL claim_ignored: got req=%b t=%0d depth=%0d expected 0 0 0", irq_req, t, depth); n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    prio[0] = 3'd2; prio[1] = 3'd4; prio[2] = 3'd0; prio[3] = 3'd0;
    e = 4'b1111; irq_i = 4'b0001;
    tick(); tick();
    claim = 1'b1;
    tick();
    claim = 1'b0;
    irq_i = 4'b0011;
    tick(); tick();
    n_checks++;
    if (obs !== {1'b1, 2'd1, 3'd4, 3'd2, 2'd1}) begin
      $display("FAIL simul_offer: got %h expected %h", obs, {1'b1, 2'd1, 3'd4, 3'd2, 2'd1}); n_fail++;
    end
    claim = 1'b1; complete = 1'b1;
    tick();
    claim = 1'b0; complete = 1'b0; irq_i = 4'b0000;
    n_checks++;
    if ({irq_req, t, depth} !== {1'b0, 3'd4, 2'd1}) begin
      $display("FAIL simul_claim_complete: got req=%b t=%0d depth=%0d expected 0 4 1", irq_req, t, depth); n_fail++;
    end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    n_checks++;
    if ({t, depth} !== {3'd0, 2'd0}) begin
      $display("FAIL simul_stack_top: got t=%0d depth=%0d expected t=0 depth=0", t, depth); n_fail++;
    end
  endtask

  task automatic test_reset_mid_nesting();
    prio[0] = 3'd3; e = 4'b1111; irq_i = 4'b0001;
    tick(); tick();
    claim = 1'b1;
    tick();
    claim = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; irq_i = 4'b0000;
    n_checks++;
    if (obs !== 11'd0) begin
      $display("FAIL reset_mid_nesting: got %h expected %h", obs, 11'd0); n_fail++;
    end
  endtask

`ifdef CLIC_EDGE_EN
  task automatic test_edge();
    do_reset();
    edge_cfg = 4'b0010;
    for (int i = 0; i < 4; i++) prio[i] = 3'd0;
    prio[1] = 3'd3; e = 4'b1111;
    irq_i = 4'b0010;
    tick();
    irq_i = 4'b0000;
    tick();
    n_checks++;
    if (obs !== {1'b1, 2'd1, 3'd3, 3'd0, 2'd0}) begin
      $display("FAIL edge_pulse_req: got %h expected %h", obs, {1'b1, 2'd1, 3'd3, 3'd0, 2'd0}); n_fail++;
    end
    tick();
    n_checks++;
    if (irq_req !== 1'b1) begin
      $display("FAIL edge_hold: got %b expected %b", irq_req, 1'b1); n_fail++;
    end
    claim = 1'b1;
    tick();
    claim = 1'b0; complete = 1'b1;
    tick();
    complete = 1'b0;
    tick();
    n_checks++;
    if ({irq_req, t, depth} !== {1'b0, 3'd0, 2'd0}) begin
      $display("FAIL edge_claim_clears: got req=%b t=%0d depth=%0d expected 0 0 0", irq_req, t, depth); n_fail++;
    end
    irq_i = 4'b0010;
    tick();
    irq_i = 4'b0000;
    tick();
    claim = 1'b1; irq_i = 4'b0010;
    tick();
    claim = 1'b0; irq_i = 4'b0000; complete = 1'b1;
    tick();
    complete = 1'b0;
    tick();
    n_checks++;
    if (obs !== {1'b1, 2'd1, 3'd3, 3'd0, 2'd0}) begin
      $display("FAIL edge_set_wins: got %h expected %h", obs, {1'b1, 2'd1, 3'd3, 3'd0, 2'd0}); n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ties_threshold();
    test_nesting_stack_full();
    test_simultaneous();
    test_reset_mid_nesting();
`ifdef CLIC_EDGE_EN
    test_edge();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
